// File: rtl/hilo_mdu.sv
// hilo_mdu: iterative multiply/divide unit owning the HI/LO pair (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Optional FAST_MUL_EN: single-cycle 32x32 multiply instead of the 33-cycle shift-add path.
module hilo_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cancel,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  state_t              state;
  logic [CW-1:0]       counter;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     operand;
  logic [XLEN-1:0]     dividend;
  logic                neg_q;
  logic                neg_r;
  logic                is_div;

  logic                accept;
  logic                signed_op;
  logic [XLEN-1:0]     abs_a;
  logic [XLEN-1:0]     abs_b;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift;
  logic [XLEN:0]       div_diff;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quot_fix;
  logic [XLEN-1:0]     rem_fix;
  logic                div_zero;
`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0]   fast_prod;
`endif

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    accept    = start && !busy && !cancel && (op >= OP_MULT) && (op <= OP_MTLO);
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    abs_a     = (signed_op && a[XLEN-1]) ? -a : a;
    abs_b     = (signed_op && b[XLEN-1]) ? -b : b;

    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, operand};

    prod_fix  = neg_q ? -acc : acc;
    quot_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix   = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    div_zero  = (operand == '0);
  end

`ifdef FAST_MUL_EN
  always_comb begin
    fast_prod = '0;
    if (op == OP_MULT)
      fast_prod = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{b[XLEN-1]}}, b});
    else
      fast_prod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      acc      <= '0;
      operand  <= '0;
      dividend <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_div   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              OP_MULT, OP_MULTU: begin
`ifdef FAST_MUL_EN
                {hi, lo} <= fast_prod;
                done     <= 1'b1;
`else
                state   <= MUL;
                busy    <= 1'b1;
                counter <= '0;
                is_div  <= 1'b0;
                acc     <= {{XLEN{1'b0}}, abs_b};
                operand <= abs_a;
                neg_q   <= signed_op && (a[XLEN-1] ^ b[XLEN-1]);
                neg_r   <= 1'b0;
`endif
              end
              OP_DIV, OP_DIVU: begin
                state    <= DIV;
                busy     <= 1'b1;
                counter  <= '0;
                is_div   <= 1'b1;
                acc      <= {{XLEN{1'b0}}, abs_a};
                operand  <= abs_b;
                dividend <= a;
                neg_q    <= signed_op && (a[XLEN-1] ^ b[XLEN-1]);
                neg_r    <= signed_op && a[XLEN-1];
              end
              default: ;
            endcase
          end
        end

        MUL, DIV: begin
          if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (state == MUL)
              acc <= {mul_sum, acc[XLEN-1:1]};
            else if (!div_diff[XLEN])
              acc <= {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
              acc <= {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            counter <= counter + 1'b1;
            if (counter == CW'(XLEN - 1))
              state <= FIX;
          end
        end

        // Sign correction and the HI/LO write happen together on the final edge
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!cancel) begin
            done <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= prod_fix;
            end else if (div_zero) begin
              hi <= dividend;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quot_fix;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: directed table, multi-cycle corner sequences and a random run
// checked against an arithmetic reference model. Honours FAST_MUL_EN for multiply latency.
module tb_hilo_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[12];

  hilo_mdu #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i);
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    cyc();
    start = 1'b0;
    op    = 3'd0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Arithmetic reference: returns {hi, lo} after the operation
  function automatic logic [63:0] model(input logic [2:0] op_i, input logic [31:0] a_i,
                                        input logic [31:0] b_i, input logic [31:0] ph,
                                        input logic [31:0] pl);
    longint sa, sb;
    int     q, r;
    logic [63:0] res;
    res = {ph, pl};
    case (op_i)
      3'd1: begin sa = $signed(a_i); sb = $signed(b_i); res = sa * sb; end
      3'd2: res = {32'd0, a_i} * {32'd0, b_i};
      3'd3: begin
        if (b_i == 0) res = {a_i, 32'hFFFFFFFF};
        else if (a_i == 32'h80000000 && b_i == 32'hFFFFFFFF) res = {32'd0, 32'h80000000};
        else begin
          q = $signed(a_i) / $signed(b_i);
          r = $signed(a_i) % $signed(b_i);
          res = {r, q};
        end
      end
      3'd4: begin
        if (b_i == 0) res = {a_i, 32'hFFFFFFFF};
        else res = {a_i % b_i, a_i / b_i};
      end
      3'd5: res = {a_i, pl};
      3'd6: res = {ph, a_i};
      default: ;
    endcase
    return res;
  endfunction

  task automatic runOp(input string name, input logic [2:0] op_i, input logic [31:0] a_i,
                       input logic [31:0] b_i, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    int bcnt;
    int exp_lat;
    applyStimulus(op_i, a_i, b_i);
    if (op_i == 3'd5 || op_i == 3'd6) begin
      checkOutput({name, " busy"}, {31'd0, busy}, 32'd0);
      checkOutput({name, " done"}, {31'd0, done}, 32'd0);
    end else begin
`ifdef FAST_MUL_EN
      exp_lat = (op_i <= 3'd2) ? 0 : 33;
`else
      exp_lat = 33;
`endif
      n = 0;
      bcnt = 0;
      while (done !== 1'b1 && n < 60) begin
        if (busy === 1'b1) bcnt++;
        cyc();
        n++;
      end
      checkOutput({name, " latency"}, 32'(n), 32'(exp_lat));
      checkOutput({name, " busy cycles"}, 32'(bcnt), 32'(exp_lat));
      checkOutput({name, " busy at done"}, {31'd0, busy}, 32'd0);
    end
    checkOutput({name, " hi"}, hi, ehi);
    checkOutput({name, " lo"}, lo, elo);
    if (op_i != 3'd5 && op_i != 3'd6) begin
      cyc();
      checkOutput({name, " done single"}, {31'd0, done}, 32'd0);
    end
    m_hi = ehi;
    m_lo = elo;
  endtask

  initial begin
    logic [63:0] expv;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          n, dcnt;

    vecs[0]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{3'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd4, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{3'd5, 32'hCAFEF00D, 32'h00000000, 32'hCAFEF00D, 32'h80000000};
    vecs[6]  = '{3'd6, 32'h00000055, 32'h00000000, 32'hCAFEF00D, 32'h00000055};
    vecs[7]  = '{3'd3, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[8]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[10] = '{3'd2, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000};
    vecs[11] = '{3'd4, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};

    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; cancel = 1'b0;
    cyc();
    cyc();
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;

    for (int i = 0; i < 12; i++)
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);

    // op 7 and start+cancel while idle must both be ignored
    applyStimulus(3'd7, 32'h11111111, 32'h2);
    checkOutput("noop busy", {31'd0, busy}, 32'd0);
    cancel = 1'b1;
    applyStimulus(3'd6, 32'hDEADBEEF, 32'h0);
    cancel = 1'b0;
    checkOutput("start+cancel lo", lo, m_lo);
    checkOutput("start+cancel hi", hi, m_hi);

    // DIVU cancelled at cycle 10, with an ignored MTHI start mid-flight
    applyStimulus(3'd4, 32'd100, 32'd7);
    for (int i = 1; i < 5; i++) cyc();
    start = 1'b1; op = 3'd5; a = 32'h0BADF00D;
    cyc();
    start = 1'b0; op = 3'd0;
    for (int i = 6; i < 10; i++) cyc();
    checkOutput("pre-cancel busy", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    checkOutput("cancel busy", {31'd0, busy}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dcnt++;
      cyc();
    end
    checkOutput("cancel no done", 32'(dcnt), 32'd0);
    checkOutput("cancel hi kept", hi, m_hi);
    checkOutput("cancel lo kept", lo, m_lo);
    runOp("divu after cancel", 3'd4, 32'd100, 32'd7, 32'd2, 32'd14);

    // reset in the middle of a DIV
    applyStimulus(3'd3, 32'h7FFFFFFF, 32'd3);
    n = 0;
    while (n < 14) begin cyc(); n++; end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checkOutput("midreset hi", hi, 32'd0);
    checkOutput("midreset lo", lo, 32'd0);
    checkOutput("midreset busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset done", {31'd0, done}, 32'd0);
    m_hi = '0;
    m_lo = '0;
    runOp("multu after reset", 3'd2, 32'd3, 32'd5, 32'd0, 32'd15);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(1, 6));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      expv = model(rop, ra, rb, m_hi, m_lo);
      runOp($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, expv[63:32], expv[31:0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_mdu.md
Name: hilo_mdu

Overview:
Iterative multiply/divide unit that owns the HI/LO register pair.
- Sits beside the execute-stage ALU and receives the same A/B operands.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO; its hi/lo outputs feed the ALU's MFHI/MFLO result path.
- Multi-cycle operations use a start/busy/done handshake so the pipeline can stall on busy and flush on cancel.

Parameters:
- XLEN, 32, operand and HI/LO width; only 32 is supported.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when not busy.
- op  in  3  1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO; 0 and 7 mean no-op.
- a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- b  in  32  rt operand (divisor / multiplier).
- cancel  in  1  exception flush; aborts any in-flight operation.
- busy  out  1  multi-cycle operation in flight.
- done  out  1  one-cycle pulse: HI/LO just updated by MUL/DIV.
- hi  out  32  current HI register.
- lo  out  32  current LO register.

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
- States: IDLE, MUL, DIV, FIX.
- Accept edge E0: first posedge with start=1, busy=0, cancel=0, op in 1..6.
  - start while busy=1 is ignored.
  - op 0/7 is ignored.
- MTHI/MTLO: hi (or lo) <= a at E0; busy stays 0; no done pulse.
- MUL (op 1/2):
  - At E0, latch operand magnitudes (two's-complement abs for MULT, raw for MULTU) and the result-sign flag (a[31]^b[31], MULT only).
  - 32 shift-add iterations, one per cycle, at E1..E32.
  - E33 (FIX): negate the 64-bit product if the sign flag is set; write {hi,lo}.
- DIV (op 3/4):
  - At E0, latch magnitudes, quotient sign (a[31]^b[31]) and remainder sign (a[31]); sign handling applies to DIV only.
  - 32 restoring-division iterations at E1..E32, one quotient bit per cycle.
  - E33 (FIX): lo <= signed-corrected quotient; hi <= remainder carrying the dividend's sign.
- Divide by zero: E33 writes lo=0xFFFFFFFF, hi=a (original value) for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no exception.
- busy timing: 1 in the cycles after E0 through the cycle before E33; 0 after E33.
- done: 1 for exactly the cycle following E33. hi/lo show the new values in that same cycle.
- cancel=1 at any edge while busy: return to IDLE, busy=0, no done, hi/lo unchanged.
- cancel together with start: the request is not accepted.
- reset mid-operation: all state returns to reset values, including hi/lo=0.
- Operand inputs may change after E0; only latched copies are used.
- 64-bit product arithmetic is modulo 2^64.

Optional Feature:
FAST_MUL_EN
- Defined: MULT/MULTU complete at E0 using a single-cycle signed/unsigned 32x32 product.
  - {hi,lo} is written at E0.
  - busy stays 0.
  - done pulses in the cycle after E0.
  - DIV is unchanged.
- Undefined: MULT/MULTU use the 33-cycle iterative path above; no hardware multiplier is inferred.

Test Plan:
1. Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001, done pulses once. With FAST_MUL_EN: done one cycle after accept, busy never 1.
2. MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU a=0x12345678 b=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MTHI a=0xCAFEF00D, next cycle MTLO a=0x00000055 -> hi=0xCAFEF00D, lo=0x00000055, busy=0 throughout, no done.
5. Start DIVU a=100 b=7, assert cancel at cycle 10 -> busy falls after that edge, no done, hi/lo keep prior values. A second start during busy is ignored; a later DIVU 100/7 gives lo=14, hi=2.
6. Assert reset at cycle 15 of a DIV -> next cycle hi=lo=0, busy=0, done=0; a new MULTU 3*5 then gives lo=15, hi=0.
